// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared encodings for the I2C engine arbiter: op codes, FSM states, defaults.
package i2c_bus_arbiter_pkg;

    localparam logic [1:0] FNC_NONE        = 2'b00;
    localparam logic [1:0] FNC_READ        = 2'b01;
    localparam logic [1:0] FNC_WRITE       = 2'b10;
    localparam logic [1:0] FNC_WRITE_MULTI = 2'b11;

    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GRANT,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    // {read, write, write_multi} one-hot for an op code; zero for FNC_NONE
    function automatic logic [2:0] start_sel(input logic [1:0] fnc);
        start_sel = {fnc == FNC_READ, fnc == FNC_WRITE, fnc == FNC_WRITE_MULTI};
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr.
module rr_priority_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] pos;

    function automatic int wrap(input int v);
        return (v >= N) ? v - N : v;
    endfunction

    // Scan from farthest to nearest so the nearest hit wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = IW'(wrap(int'(rr_ptr) + k));
            if (req[pos]) begin
                gnt      = '0;
                gnt[pos] = 1'b1;
                idx      = pos;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C engine among N_REQ requester FSMs.
// Define I2C_ARB_TIMEOUT_EN to add a WAIT-state watchdog of TIMEOUT_CYCLES.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int          N_REQ          = 4,
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_go,
    input  logic [2*N_REQ-1:0]   req_fnc_sel,
    input  logic [8*N_REQ-1:0]   req_reg_address,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [4*N_REQ-1:0]   req_n_bytes,
    input  logic [N_REQ-1:0]     req_fifo_wr_en,
    input  logic [N_REQ-1:0]     req_fifo_read_en,
    input  logic [8*N_REQ-1:0]   req_fifo_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     req_done,
    output logic [N_REQ-1:0]     req_error,
    output logic                 read_start,
    output logic                 write_start,
    output logic                 write_multi_start,
    input  logic                 read_done,
    input  logic                 write_done,
    input  logic                 write_multi_done,
    output logic [1:0]           fnc_sel,
    output logic [7:0]           reg_address_out,
    output logic [7:0]           data_out,
    output logic [3:0]           n_bytes,
    output logic                 fifo_wr_en,
    output logic                 fifo_read_en,
    output logic [7:0]           fifo_data_out,
    output logic                 busy
);

    localparam int IW = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    rr_q, rr_d;
    logic [1:0]       op_q, op_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [N_REQ-1:0] err_q, err_d;
    logic [2:0]       start_q, start_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             req_sel;
    logic             go_sel;
    logic             hit;
    logic [IW-1:0]    ptr_next;

`ifdef I2C_ARB_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    rr_priority_pick #(
        .N (N_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_q),
        .gnt    (pick_gnt),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign req_sel  = |(req & gnt_q);
    assign go_sel   = |(req_go & gnt_q);
    assign hit      = |(start_sel(op_q) & {read_done, write_done, write_multi_done});
    assign ptr_next = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        op_d    = op_q;
        done_d  = '0;
        err_d   = '0;
        start_d = '0;
`ifdef I2C_ARB_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_gnt;
                    idx_d   = pick_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!req_sel) begin
                    gnt_d   = '0;
                    rr_d    = ptr_next;
                    state_d = ST_IDLE;
                end else if (go_sel) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                op_d    = fnc_sel;
                start_d = start_sel(fnc_sel);
                state_d = ST_WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
                wd_d    = '0;
`endif
                if (fnc_sel == FNC_NONE) begin
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (hit) begin
                    done_d  = gnt_q;
                    state_d = ST_HOLD;
`ifdef I2C_ARB_TIMEOUT_EN
                end else if (wd_q == TIMEOUT_CYCLES - 16'd1) begin
                    done_d  = gnt_q;
                    err_d   = gnt_q;
                    state_d = ST_HOLD;
                end else begin
                    wd_d = wd_q + 16'd1;
`endif
                end
            end
            ST_HOLD: begin
                if (!req_sel) begin
                    gnt_d   = '0;
                    rr_d    = ptr_next;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
            op_q    <= FNC_NONE;
            done_q  <= '0;
            err_q   <= '0;
            start_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            op_q    <= op_d;
            done_q  <= done_d;
            err_q   <= err_d;
            start_q <= start_d;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Grant is one-hot or zero, so a priority-free select is enough
    always_comb begin
        fnc_sel         = '0;
        reg_address_out = '0;
        data_out        = '0;
        n_bytes         = '0;
        fifo_wr_en      = 1'b0;
        fifo_read_en    = 1'b0;
        fifo_data_out   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                fnc_sel         = req_fnc_sel[2*i +: 2];
                reg_address_out = req_reg_address[8*i +: 8];
                data_out        = req_data[8*i +: 8];
                n_bytes         = req_n_bytes[4*i +: 4];
                fifo_wr_en      = req_fifo_wr_en[i];
                fifo_read_en    = req_fifo_read_en[i];
                fifo_data_out   = req_fifo_data[8*i +: 8];
            end
        end
    end

    assign gnt               = gnt_q;
    assign req_done          = done_q;
    assign req_error         = err_q;
    assign read_start        = start_q[2];
    assign write_start       = start_q[1];
    assign write_multi_start = start_q[0];
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: vector table, corner sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_i2c_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req, req_go, req_fifo_wr_en, req_fifo_read_en;
    logic [7:0]  req_fnc_sel;
    logic [31:0] req_reg_address, req_data, req_fifo_data;
    logic [15:0] req_n_bytes;
    logic [3:0]  gnt, req_done, req_error;
    logic        read_start, write_start, write_multi_start;
    logic        read_done, write_done, write_multi_done;
    logic [1:0]  fnc_sel;
    logic [7:0]  reg_address_out, data_out, fifo_data_out;
    logic [3:0]  n_bytes;
    logic        fifo_wr_en, fifo_read_en, busy;
    logic [2:0]  starts;

    int n_vec = 0;
    int n_bad = 0;
    logic [3:0] want;
    int ptr;

    always #5 clk = ~clk;

    assign starts = {read_start, write_start, write_multi_start};

    i2c_bus_arbiter #(
        .N_REQ          (4),
        .TIMEOUT_CYCLES (16'd100)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req               (req),
        .req_go            (req_go),
        .req_fnc_sel       (req_fnc_sel),
        .req_reg_address   (req_reg_address),
        .req_data          (req_data),
        .req_n_bytes       (req_n_bytes),
        .req_fifo_wr_en    (req_fifo_wr_en),
        .req_fifo_read_en  (req_fifo_read_en),
        .req_fifo_data     (req_fifo_data),
        .gnt               (gnt),
        .req_done          (req_done),
        .req_error         (req_error),
        .read_start        (read_start),
        .write_start       (write_start),
        .write_multi_start (write_multi_start),
        .read_done         (read_done),
        .write_done        (write_done),
        .write_multi_done  (write_multi_done),
        .fnc_sel           (fnc_sel),
        .reg_address_out   (reg_address_out),
        .data_out          (data_out),
        .n_bytes           (n_bytes),
        .fifo_wr_en        (fifo_wr_en),
        .fifo_read_en      (fifo_read_en),
        .fifo_data_out     (fifo_data_out),
        .busy              (busy)
    );

    typedef struct {
        int         w;
        logic [1:0] f;
        logic [7:0] addr;
        logic [2:0] st;
        bit         err;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {gnt, busy, req_done, req_error, starts, fnc_sel, reg_address_out,
                data_out, n_bytes, fifo_wr_en, fifo_read_en, fifo_data_out};
    endfunction

    // Reference: op code -> which engine start must pulse
    function automatic logic [2:0] model_start(input logic [1:0] f);
        case (f)
            2'b01:   return 3'b100;
            2'b10:   return 3'b010;
            2'b11:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int model_pick(input logic [3:0] pend, input int p);
        for (int k = 0; k < 4; k++)
            if (pend[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    // Called in IDLE with req already showing requester w
    task automatic serve(input int w, input logic [1:0] f, input logic [2:0] exp_st,
                         input bit exp_err, input bit drop_g, input int wcyc, input int hcyc);
        logic [3:0] oh;
        int k;
        oh = 4'(1 << w);
        req_fnc_sel[2*w +: 2] = f;
        step();
        chk("grant", gnt, oh);
        chk("busy_grant", busy, 1);
        chk("mux_addr", reg_address_out, req_reg_address[8*w +: 8]);
        chk("mux_data", data_out, req_data[8*w +: 8]);
        chk("mux_nbytes", n_bytes, req_n_bytes[4*w +: 4]);
        chk("mux_fnc", fnc_sel, f);
        if (drop_g) begin
            req[w] = 1'b0;
            want[w] = 1'b0;
            step();
            chk("grant_drop", {gnt, busy, starts}, 0);
            ptr = (w + 1) % 4;
        end else begin
            req_go[w] = 1'b1;
            step();
            req_go[w] = 1'b0;
            chk("issue_quiet", {starts, req_done}, 0);
            step();
            chk("start", starts, exp_st);
            if (exp_err) begin
                chk("invalid_pulse", {req_done, req_error}, {oh, oh});
            end else begin
                chk("start_no_done", {req_done, req_error}, 0);
                k = 0;
                for (int b = 0; b < 3; b++)
                    if (exp_st[b]) k = b;
                for (int c = 0; c < wcyc; c++) begin
                    {read_done, write_done, write_multi_done} =
                        3'(1 << ((k + int'($urandom_range(1, 2))) % 3));
                    want = want | 4'($urandom_range(0, 15));
                    req = want;
                    step();
                    {read_done, write_done, write_multi_done} = 3'b000;
                    chk("wrong_done_ignored", {req_done, starts}, 0);
                end
                {read_done, write_done, write_multi_done} = exp_st;
                step();
                {read_done, write_done, write_multi_done} = 3'b000;
                chk("done", {req_done, req_error}, {oh, 4'b0});
            end
            step();
            chk("done_one_cycle", {req_done, req_error}, 0);
            chk("hold_gnt", gnt, oh);
            for (int c = 0; c < hcyc; c++) begin
                req_fifo_data[8*w +: 8] = 8'($urandom);
                req_fifo_read_en[w] = 1'($urandom_range(0, 1));
                req_fifo_wr_en[w] = 1'($urandom_range(0, 1));
                #1;
                chk("fifo_mux", {fifo_data_out, fifo_read_en, fifo_wr_en},
                    {req_fifo_data[8*w +: 8], req_fifo_read_en[w], req_fifo_wr_en[w]});
                step();
            end
            req[w] = 1'b0;
            want[w] = 1'b0;
            step();
            chk("release", {gnt, busy}, 0);
            chk("idle_zero", {fnc_sel, reg_address_out, fifo_data_out}, 0);
            ptr = (w + 1) % 4;
        end
    endtask

    initial begin
        vec_t tbl[5];
        int w;
        bit early;

        tbl[0] = '{2, 2'b01, 8'h50, 3'b100, 1'b0};
        tbl[1] = '{0, 2'b10, 8'h3C, 3'b010, 1'b0};
        tbl[2] = '{3, 2'b11, 8'hA7, 3'b001, 1'b0};
        tbl[3] = '{1, 2'b00, 8'h11, 3'b000, 1'b1};
        tbl[4] = '{2, 2'b00, 8'hFE, 3'b000, 1'b1};

        reset_n = 1'b0;
        req = '0; req_go = '0; req_fifo_wr_en = '0; req_fifo_read_en = '0;
        req_fnc_sel = '0; req_reg_address = '0; req_data = '0;
        req_fifo_data = '0; req_n_bytes = '0;
        read_done = 1'b0; write_done = 1'b0; write_multi_done = 1'b0;
        want = '0;
        ptr = 0;
        repeat (2) step();
        chk("reset_outputs", outs(), 0);
        reset_n = 1'b1;
        step();

        // Two requesters from reset, released in turn
        want = 4'b0101;
        req = want;
        step();
        chk("rr_first", gnt, 4'b0001);
        req[0] = 1'b0;
        want[0] = 1'b0;
        step();
        chk("rr_release0", {gnt, busy, starts}, 0);
        step();
        chk("rr_second", gnt, 4'b0100);
        req[2] = 1'b0;
        want = '0;
        step();
        chk("rr_idle", {gnt, busy, starts}, 0);
        ptr = 3;

        for (int i = 0; i < 5; i++) begin
            w = tbl[i].w;
            req_reg_address[8*w +: 8] = tbl[i].addr;
            req_data = 32'hC0DE_1234;
            req_n_bytes = 16'hA5C3;
            want = 4'(1 << w);
            req = want;
            serve(w, tbl[i].f, tbl[i].st, tbl[i].err, 1'b0, i, 1);
        end

        // Watchdog: read issued, engine never answers
        want = 4'b0010;
        req = want;
        req_fnc_sel[3:2] = 2'b01;
        step();
        chk("to_grant", gnt, 4'b0010);
        req_go[1] = 1'b1;
        step();
        req_go[1] = 1'b0;
        step();
        chk("to_start", starts, 3'b100);
        early = 1'b0;
        for (int c = 1; c < 100; c++) begin
            step();
            if (req_done != 0 || req_error != 0) early = 1'b1;
        end
        chk("to_no_early", early, 0);
        step();
`ifdef I2C_ARB_TIMEOUT_EN
        chk("to_error", {req_done, req_error}, {4'b0010, 4'b0010});
`else
        chk("to_stuck", {busy, gnt, req_done, req_error}, {1'b1, 4'b0010, 8'h00});
        repeat (50) step();
        chk("to_still_wait", {busy, gnt, req_done}, {1'b1, 4'b0010, 4'b0});
        read_done = 1'b1;
        step();
        read_done = 1'b0;
        chk("to_late_done", {req_done, req_error}, {4'b0010, 4'b0});
`endif
        step();
        req = '0;
        want = '0;
        step();
        chk("to_release", {gnt, busy}, 0);
        ptr = 2;

        // Randomized traffic against the round-robin model
        for (int t = 0; t < 40; t++) begin
            if (want == 0) want = 4'($urandom_range(1, 15));
            else want = want | 4'($urandom_range(0, 15));
            req = want;
            req_reg_address = $urandom;
            req_data = $urandom;
            req_n_bytes = 16'($urandom);
            req_fnc_sel = 8'($urandom);
            w = model_pick(want, ptr);
            begin
                logic [1:0] f;
                f = 2'($urandom_range(0, 3));
                serve(w, f, model_start(f), f == 2'b00,
                      $urandom_range(0, 5) == 0,
                      $urandom_range(0, 4), $urandom_range(0, 3));
            end
        end
        req = '0;
        want = '0;
        step();
        step();

        // Reset while waiting on the engine
        want = 4'b0010;
        req = want;
        req_fnc_sel[3:2] = 2'b01;
        step();
        req_go[1] = 1'b1;
        step();
        req_go[1] = 1'b0;
        step();
        chk("rst_wait_start", starts, 3'b100);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async", outs(), 0);
        req = '0;
        want = '0;
        step();
        reset_n = 1'b1;
        read_done = 1'b1;
        step();
        read_done = 1'b0;
        chk("rst_done_ignored", {req_done, req_error, busy}, 0);
        want = 4'b1111;
        req = want;
        step();
        chk("rst_rr_ptr", gnt, 4'b0001);
        req = '0;
        want = '0;
        step();
        chk("rst_final_idle", {gnt, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
